checker_csr_mc: RTL and testbench
=================================

// Module: checker_csr_mc
// PURPOSE
//  Multi-channel CSR/control bank for checker engines; generalises the single-channel checker CTRL/STAT/ADDRESS
//  register set to NCH independent channels, each with its own run FSM, status flags and IRQ enable.
//  Sits between the CSR bus and NCH checker cores; one aggregated level irq to the interrupt controller.
// PARAMETERS
//  CSR_ADDR  4'h0   bank select, matched against csr_a[13:10]
//  NCH       4      channel count, 1..16
//  ADDR_W    48     target address width per channel, 33..64 (LOW = [31:0], HIGH = [ADDR_W-1:32])
//  TIMEOUT   1024   watchdog limit in sys_clk cycles, >=2 (used only with CHECKER_CSR_MC_TIMEOUT_EN)
// PORTS
//  sys_clk     in   1          clock
//  sys_rst_n   in   1          asynchronous active-low reset
//  csr_a       in   14         CSR word address
//  csr_we      in   1          CSR write strobe
//  csr_di      in   32         CSR write data
//  csr_do      out  32         CSR read data, registered
//  ch_start    out  NCH        one-cycle start pulse per channel
//  ch_mode     out  2*NCH      per-channel mode (0 dummy, 1 single, 2 continuous, 3 reserved)
//  ch_addr     out  ADDR_W*NCH per-channel target address
//  ch_done     in   NCH        one-cycle completion pulse from core
//  ch_error    in   NCH        one-cycle error pulse from core
//  irq         out  1          OR over channels of (STAT.done|STAT.error) & CTRL.irq_en
// BEHAVIOUR
//  Decode: selected = csr_a[13:10]==CSR_ADDR; channel = csr_a[5:2]; reg = csr_a[1:0]; channel>=NCH ignored, reads 0.
//  Regs: 0 CTRL {irq_en[3], mode[2:1], start[0]}; 1 STAT {busy[2], error[1], done[0]}, W1C on [1:0];
//   2 ADDRESS_LOW; 3 ADDRESS_HIGH (bits above ADDR_W-32 read 0). CTRL.start reads back busy.
//  Read: csr_do <= selected data one cycle after csr_a; 0 when not selected. Writes take effect on the edge.
//  Per-channel FSM: IDLE -> RUN on CTRL write with start=1 and mode!=3; ch_start high exactly the next cycle,
//   busy set same edge. RUN -> IDLE on ch_done (done<=1) or ch_error (error<=1); both same cycle: both set.
//   Mode 2 (continuous): ch_done sets done but stays RUN and re-pulses ch_start next cycle;
//   exits only on ch_error or CTRL write start=0 (clean stop, no flag set).
//  Start with mode=3: no pulse, stays IDLE, error<=1 next edge.
//  While busy: CTRL start=1 write ignored; mode and ADDRESS writes ignored; irq_en write accepted.
//  ch_done/ch_error in IDLE ignored. STAT W1C and flag set same cycle: set wins.
//  irq combinational from registered flags; level held until software clears STAT.
//  Reset (any time, incl. mid-run): all regs 0, FSMs IDLE, ch_start 0, ch_mode 0, ch_addr 0, csr_do 0, irq 0.
// CONFIGURATION
//  CHECKER_CSR_MC_TIMEOUT_EN defined: per-channel counter, cleared on each ch_start, increments in RUN;
//   reaching TIMEOUT-1 forces IDLE, error<=1, STAT bit3 timeout<=1 (W1C); stale ch_done afterwards ignored.
//  Undefined: no counter, STAT bit3 reads 0, RUN waits indefinitely.
// TESTING
//  CTRL ch1 = 0x8, read back -> 0x8 one cycle later; ch0 CTRL untouched (reads 0).
//  ch0 ADDRESS_LOW=0x10, HIGH=0x1; CTRL=0x3 (single, start) -> ch_start[0] 1 cycle, ch_addr[0]=0x1_0000_0010, STAT=0x4.
//  Same run, ch_done[0] pulse with irq_en=1 -> STAT=0x1, irq=1; write STAT 0x7 -> STAT=0, irq=0.
//  ch2 CTRL=0x6|1 (mode 3) -> no ch_start, STAT.error=1; ch3 ch_done+ch_error same cycle -> STAT=0x3.
//  TIMEOUT_EN, TIMEOUT=16: start ch0, no done -> STAT=0xA after 16 cycles; late ch_done ignored.
//  Assert sys_rst_n=0 mid-run on all channels -> all outputs 0 immediately; after release reg reads all 0.

Source files
------------

// File: rtl/checker_csr_mc.sv
// Multi-channel CSR/control bank for checker engines: per-channel CTRL/STAT/ADDRESS registers, run FSM, aggregated irq.
// Optional per-channel watchdog: define CHECKER_CSR_MC_TIMEOUT_EN.
module checker_csr_mc #(
  parameter logic [3:0] CSR_ADDR = 4'h0,
  parameter int         NCH      = 4,
  parameter int         ADDR_W   = 48,
  parameter int         TIMEOUT  = 1024
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [13:0]             csr_a,
  input  logic                    csr_we,
  input  logic [31:0]             csr_di,
  output logic [31:0]             csr_do,
  output logic [NCH-1:0]          ch_start,
  output logic [2*NCH-1:0]        ch_mode,
  output logic [ADDR_W*NCH-1:0]   ch_addr,
  input  logic [NCH-1:0]          ch_done,
  input  logic [NCH-1:0]          ch_error,
  output logic                    irq
);

  localparam int HW = ADDR_W - 32;

`ifdef CHECKER_CSR_MC_TIMEOUT_EN
  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
`endif

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  logic        sel;
  logic [3:0]  ch_sel;
  logic [1:0]  reg_sel;
  logic [31:0] rd_word [16];
  logic [15:0] irq_vec;
  logic        unused_ok;

  assign sel     = (csr_a[13:10] == CSR_ADDR);
  assign ch_sel  = csr_a[5:2];
  assign reg_sel = csr_a[1:0];

  // Address bits [9:6] are not decoded; TIMEOUT only matters with the watchdog enabled.
  assign unused_ok = ^{csr_a[9:6], (TIMEOUT > 1)};

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_ch
      if (gi < NCH) begin : g_on
        state_t          state_reg;
        logic            irq_en_reg;
        logic            done_reg;
        logic            error_reg;
        logic            start_reg;
        logic [1:0]      mode_reg;
        logic [31:0]     addr_lo_reg;
        logic [HW-1:0]   addr_hi_reg;
        logic            tmo_bit;
        logic            busy;
        logic            hit;
        logic            wr_ctrl;
        logic            wr_stat;
        logic            wr_lo;
        logic            wr_hi;
        logic [31:0]     hi_word;
        logic [31:0]     rd_data;
`ifdef CHECKER_CSR_MC_TIMEOUT_EN
        logic [CW-1:0]   cnt_reg;
        logic            tmo_reg;
        assign tmo_bit = tmo_reg;
`else
        assign tmo_bit = 1'b0;
`endif

        assign busy    = (state_reg == ST_RUN);
        assign hit     = csr_we && sel && (ch_sel == 4'(gi));
        assign wr_ctrl = hit && (reg_sel == 2'd0);
        assign wr_stat = hit && (reg_sel == 2'd1);
        assign wr_lo   = hit && (reg_sel == 2'd2);
        assign wr_hi   = hit && (reg_sel == 2'd3);

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
          if (!sys_rst_n) begin
            state_reg   <= ST_IDLE;
            irq_en_reg  <= 1'b0;
            done_reg    <= 1'b0;
            error_reg   <= 1'b0;
            start_reg   <= 1'b0;
            mode_reg    <= 2'd0;
            addr_lo_reg <= '0;
            addr_hi_reg <= '0;
`ifdef CHECKER_CSR_MC_TIMEOUT_EN
            cnt_reg     <= '0;
            tmo_reg     <= 1'b0;
`endif
          end else begin
            start_reg <= 1'b0;
            // W1C first so that a flag set later in this block wins the same cycle.
            if (wr_stat) begin
              if (csr_di[0]) done_reg  <= 1'b0;
              if (csr_di[1]) error_reg <= 1'b0;
`ifdef CHECKER_CSR_MC_TIMEOUT_EN
              if (csr_di[3]) tmo_reg   <= 1'b0;
`endif
            end
            if (wr_ctrl) irq_en_reg <= csr_di[3];

            case (state_reg)
              ST_IDLE: begin
                if (wr_lo) addr_lo_reg <= csr_di;
                if (wr_hi) addr_hi_reg <= csr_di[HW-1:0];
                if (wr_ctrl) begin
                  mode_reg <= csr_di[2:1];
                  if (csr_di[0]) begin
                    if (csr_di[2:1] == 2'd3) begin
                      error_reg <= 1'b1;
                    end else begin
                      state_reg <= ST_RUN;
                      start_reg <= 1'b1;
`ifdef CHECKER_CSR_MC_TIMEOUT_EN
                      cnt_reg   <= '0;
`endif
                    end
                  end
                end
              end
              ST_RUN: begin
                if (ch_error[gi]) begin
                  error_reg <= 1'b1;
                  if (ch_done[gi]) done_reg <= 1'b1;
                  state_reg <= ST_IDLE;
                end else if (ch_done[gi]) begin
                  done_reg <= 1'b1;
                  if (mode_reg == 2'd2) begin
                    start_reg <= 1'b1;
`ifdef CHECKER_CSR_MC_TIMEOUT_EN
                    cnt_reg   <= '0;
`endif
                  end else begin
                    state_reg <= ST_IDLE;
                  end
                end else if (wr_ctrl && !csr_di[0] && (mode_reg == 2'd2)) begin
                  state_reg <= ST_IDLE;
`ifdef CHECKER_CSR_MC_TIMEOUT_EN
                end else if (cnt_reg == TMO_LAST) begin
                  state_reg <= ST_IDLE;
                  error_reg <= 1'b1;
                  tmo_reg   <= 1'b1;
                end else begin
                  cnt_reg <= cnt_reg + 1'b1;
`endif
                end
              end
              default: state_reg <= ST_IDLE;
            endcase
          end
        end

        always_comb begin
          hi_word = '0;
          hi_word[HW-1:0] = addr_hi_reg;
          rd_data = '0;
          case (reg_sel)
            2'd0:    rd_data[3:0] = {irq_en_reg, mode_reg, busy};
            2'd1:    rd_data[3:0] = {tmo_bit, busy, error_reg, done_reg};
            2'd2:    rd_data      = addr_lo_reg;
            default: rd_data      = hi_word;
          endcase
        end

        assign rd_word[gi]                    = rd_data;
        assign irq_vec[gi]                    = (done_reg | error_reg) & irq_en_reg;
        assign ch_start[gi]                   = start_reg;
        assign ch_mode[2*gi +: 2]             = mode_reg;
        assign ch_addr[ADDR_W*gi +: ADDR_W]   = {addr_hi_reg, addr_lo_reg};
      end else begin : g_off
        assign rd_word[gi] = '0;
        assign irq_vec[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      csr_do <= '0;
    end else begin
      csr_do <= sel ? rd_word[ch_sel] : '0;
    end
  end

  assign irq = |irq_vec;

endmodule

// File: tb/tb_checker_csr_mc.sv
// Directed bench for checker_csr_mc: register access, run FSM, flags, irq, watchdog and reset behaviour.
module tb_checker_csr_mc;
  localparam int NCH     = 4;
  localparam int ADDR_W  = 48;
  localparam int TIMEOUT = 16;
`ifdef CHECKER_CSR_MC_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic                  sys_clk = 1'b0;
  logic                  sys_rst_n = 1'b0;
  logic [13:0]           csr_a = '0;
  logic                  csr_we = 1'b0;
  logic [31:0]           csr_di = '0;
  logic [31:0]           csr_do;
  logic [NCH-1:0]        ch_start;
  logic [2*NCH-1:0]      ch_mode;
  logic [ADDR_W*NCH-1:0] ch_addr;
  logic [NCH-1:0]        ch_done = '0;
  logic [NCH-1:0]        ch_error = '0;
  logic                  irq;

  int n_cmp = 0;
  int n_bad = 0;

  checker_csr_mc #(
    .CSR_ADDR(4'h0), .NCH(NCH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di), .csr_do(csr_do),
    .ch_start(ch_start), .ch_mode(ch_mode), .ch_addr(ch_addr),
    .ch_done(ch_done), .ch_error(ch_error), .irq(irq)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  function automatic logic [13:0] caddr(input int bank, input int ch, input int r);
    logic [3:0] b4;
    logic [3:0] c4;
    logic [1:0] r2;
    b4 = bank[3:0];
    c4 = ch[3:0];
    r2 = r[1:0];
    return {b4, 4'h0, c4, r2};
  endfunction

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic csr_write(input int ch, input int r, input logic [31:0] d, input int bank = 0);
    csr_a  = caddr(bank, ch, r);
    csr_we = 1'b1;
    csr_di = d;
    @(posedge sys_clk);
    #1;
    csr_we = 1'b0;
    csr_di = '0;
  endtask

  task automatic csr_read(input int ch, input int r, output logic [31:0] d, input int bank = 0);
    csr_a  = caddr(bank, ch, r);
    csr_we = 1'b0;
    @(posedge sys_clk);
    #1;
    d = csr_do;
  endtask

  task automatic pulse(input logic [NCH-1:0] d, input logic [NCH-1:0] e);
    ch_done  = d;
    ch_error = e;
    @(posedge sys_clk);
    #1;
    ch_done  = '0;
    ch_error = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] rd;

    // Reset state
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_ch_start", 64'(ch_start), 64'h0);
    check("rst_irq", 64'(irq), 64'h0);
    check("rst_csr_do", 64'(csr_do), 64'h0);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;

    // CTRL read-back on ch1, ch0 untouched
    csr_write(1, 0, 32'h8);
    csr_read(1, 0, rd);  check("ch1_ctrl", 64'(rd), 64'h8);
    csr_read(0, 0, rd);  check("ch0_ctrl_untouched", 64'(rd), 64'h0);
    check("irq_no_flags", 64'(irq), 64'h0);

    // Single run on ch0
    csr_write(0, 2, 32'h10);
    csr_write(0, 3, 32'h1);
    csr_write(0, 0, 32'h3);
    check("ch0_start_pulse", 64'(ch_start), 64'h1);
    check("ch0_addr", 64'(ch_addr[ADDR_W-1:0]), 64'h1_0000_0010);
    check("ch0_mode", 64'(ch_mode[1:0]), 64'h1);
    csr_read(0, 1, rd);  check("ch0_stat_busy", 64'(rd), 64'h4);
    check("ch0_start_one_cycle", 64'(ch_start), 64'h0);
    csr_read(0, 0, rd);  check("ch0_ctrl_busy", 64'(rd), 64'h3);
    csr_write(0, 0, 32'h8);             // irq_en while busy, mode write ignored
    csr_write(0, 2, 32'hFF);            // address write ignored while busy
    check("ch0_addr_locked", 64'(ch_addr[ADDR_W-1:0]), 64'h1_0000_0010);
    check("ch0_mode_locked", 64'(ch_mode[1:0]), 64'h1);
    csr_read(0, 1, rd);  check("ch0_still_busy", 64'(rd), 64'h4);
    pulse(4'b0001, 4'b0000);
    check("ch0_irq_done", 64'(irq), 64'h1);
    csr_read(0, 1, rd);  check("ch0_stat_done", 64'(rd), 64'h1);
    csr_write(0, 1, 32'h7);
    csr_read(0, 1, rd);  check("ch0_stat_cleared", 64'(rd), 64'h0);
    check("ch0_irq_cleared", 64'(irq), 64'h0);

    // Reserved mode on ch2, simultaneous done/error on ch3
    csr_write(2, 0, 32'h7);
    check("ch2_no_start", 64'(ch_start), 64'h0);
    csr_read(2, 1, rd);  check("ch2_stat_err", 64'(rd), 64'h2);
    csr_write(3, 0, 32'h3);
    pulse(4'b1000, 4'b1000);
    csr_read(3, 1, rd);  check("ch3_stat_both", 64'(rd), 64'h3);
    check("irq_masked", 64'(irq), 64'h0);

    // Continuous mode on ch1
    csr_write(1, 0, 32'hD);
    check("ch1_start", 64'(ch_start), 64'h2);
    pulse(4'b0010, 4'b0000);
    check("ch1_restart", 64'(ch_start), 64'h2);
    csr_read(1, 1, rd);  check("ch1_stat_cont", 64'(rd), 64'h5);
    check("ch1_no_extra_start", 64'(ch_start), 64'h0);
    csr_write(1, 0, 32'hC);
    csr_read(1, 1, rd);  check("ch1_clean_stop", 64'(rd), 64'h1);
    check("ch1_irq", 64'(irq), 64'h1);
    csr_write(1, 1, 32'h3);
    check("ch1_irq_cleared", 64'(irq), 64'h0);

    // W1C and done set in the same cycle: set wins
    csr_write(0, 0, 32'hB);
    csr_a    = caddr(0, 0, 1);
    csr_we   = 1'b1;
    csr_di   = 32'h1;
    ch_done  = 4'b0001;
    @(posedge sys_clk);
    #1;
    csr_we   = 1'b0;
    csr_di   = '0;
    ch_done  = '0;
    csr_read(0, 1, rd);  check("ch0_set_wins", 64'(rd), 64'h1);
    csr_write(0, 1, 32'h3);

    // Watchdog boundary (or indefinite wait when disabled)
    csr_write(0, 0, 32'hB);
    repeat (15) @(posedge sys_clk);
    #1;
    csr_read(0, 1, rd);  check("tmo_before_limit", 64'(rd), 64'h4);
    csr_read(0, 1, rd);  check("tmo_at_limit", 64'(rd), TMO_EN ? 64'hA : 64'h4);
    pulse(4'b0001, 4'b0000);
    csr_read(0, 1, rd);  check("tmo_late_done", 64'(rd), TMO_EN ? 64'hA : 64'h1);
    csr_write(0, 1, 32'hF);
    csr_read(0, 1, rd);  check("tmo_cleared", 64'(rd), 64'h0);

    // Reset in the middle of runs on all channels
    csr_write(3, 2, 32'hDEAD_BEEF);
    csr_write(1, 0, 32'hB);
    csr_write(2, 0, 32'hB);
    csr_write(3, 0, 32'hB);
    csr_read(3, 2, rd);  check("ch3_addr_lo", 64'(rd), 64'hDEAD_BEEF);
    csr_write(0, 0, 32'hB);
    check("pre_rst_start", 64'(ch_start), 64'h1);
    check("pre_rst_irq", 64'(irq), 64'h1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("mid_rst_start", 64'(ch_start), 64'h0);
    check("mid_rst_mode", 64'(ch_mode), 64'h0);
    check("mid_rst_addr_lo", 64'(ch_addr[95:0] | ch_addr[191:96]), 64'h0);
    check("mid_rst_irq", 64'(irq), 64'h0);
    check("mid_rst_csr_do", 64'(csr_do), 64'h0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      for (int r = 0; r < 4; r++) begin
        csr_read(c, r, rd);
        check($sformatf("post_rst_ch%0d_r%0d", c, r), 64'(rd), 64'h0);
      end
    end

    // Out-of-range channel and foreign bank are ignored
    csr_write(5, 0, 32'h8);
    csr_read(5, 0, rd);  check("ch5_reads_zero", 64'(rd), 64'h0);
    csr_write(0, 0, 32'h8, 1);
    csr_read(0, 0, rd);  check("bank1_no_effect", 64'(rd), 64'h0);
    csr_write(0, 0, 32'h8);
    csr_read(0, 0, rd, 1); check("bank1_reads_zero", 64'(rd), 64'h0);
    csr_read(0, 0, rd);  check("bank0_ctrl", 64'(rd), 64'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
